// File: rtl/btn_charge_pkg.sv
// btn_charge_pkg: shared types and constants for the press-to-charge front end.
//   state_t      - charge FSM states (IDLE / CHARGE / DONE)
//   V_W          - launch velocity width, shared with the game FSM and jump block
//   SQUEEZE_MAX  - largest compression level reported on o_squeeze
package btn_charge_pkg;

  localparam int unsigned V_W         = 8;
  localparam logic [3:0]  SQUEEZE_MAX = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHARGE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus stable-level debouncer.
//   clk, rst   - clock, asynchronous active-high reset
//   i_btn      - raw asynchronous button
//   o_btn_db   - debounced level
//   o_press    - one-clock pulse, coincident with a rising o_btn_db edge
//   o_release  - one-clock pulse, coincident with a falling o_btn_db edge
// The level toggles only after DEBOUNCE_CYCLES consecutive disagreeing samples;
// any agreeing sample restarts the count.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_btn_db,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          r_release;
  logic          w_diff;
  logic          w_flip;

  assign w_diff = r_sync2 ^ r_db;
  assign w_flip = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_db      <= 1'b0;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_press   <= w_flip && !r_db;
      r_release <= w_flip && r_db;
      if (!w_diff || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_flip) begin
        r_db <= ~r_db;
      end
    end
  end

  assign o_btn_db  = r_db;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/btn_charge.sv
// btn_charge: conditions the player button, measures hold time and converts it
// into a launch velocity (valid/ack handshake) plus a live squeeze level.
//   clk, rst    - game clock, asynchronous active-high reset
//   i_btn       - raw bouncy button
//   i_arm       - charging permitted while high
//   i_ack       - consumer has taken o_v_init
//   o_charging  - high in CHARGE
//   o_squeeze   - compression level 0..14 (0 outside CHARGE)
//   o_v_init    - launch velocity, held outside CHARGE
//   o_valid     - o_v_init final and pending
// Optional macro BTN_CHARGE_TIMEOUT_EN: auto-release after TIMEOUT_TICKS tick
// wraps spent at V_MAX.
module btn_charge
  import btn_charge_pkg::*;
#(
  parameter int unsigned    DEBOUNCE_CYCLES = 500000,
  parameter int unsigned    TICK_CYCLES     = 250000,
  parameter logic [V_W-1:0] V_MIN           = 8'd16,
  parameter logic [V_W-1:0] V_MAX           = 8'd200,
  parameter int unsigned    SQ_SHIFT        = 3,
  parameter int unsigned    TIMEOUT_TICKS   = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_btn,
  input  logic           i_arm,
  input  logic           i_ack,
  output logic           o_charging,
  output logic [3:0]     o_squeeze,
  output logic [V_W-1:0] o_v_init,
  output logic           o_valid
);

  localparam int unsigned TW = (TICK_CYCLES < 2) ? 1 : $clog2(TICK_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  state_t         r_state;
  state_t         w_next;
  logic [TW-1:0]  r_tick;
  logic [V_W-1:0] r_v;
  logic [3:0]     r_sq;
  logic           r_charging;
  logic           r_valid;
  logic           w_press;
  logic           w_release;
  logic           w_btn_db;
  logic           w_wrap;
  logic           w_enter;
  logic           w_timeout;
  logic [V_W-1:0] w_sq_full;
  logic [3:0]     w_sq_d;
  logic           w_charging_d;
  logic           w_valid_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (i_btn),
    .o_btn_db (w_btn_db),
    .o_press  (w_press),
    .o_release(w_release)
  );

  assign w_wrap  = (r_tick == TICK_LAST);
  assign w_enter = (r_state != ST_CHARGE) && (w_next == ST_CHARGE);

`ifdef BTN_CHARGE_TIMEOUT_EN
  localparam int unsigned TOW = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_TICKS - 1);

  logic [TOW-1:0] r_to;

  // Counts only wraps that occur while already saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to <= '0;
    end else if (w_enter) begin
      r_to <= '0;
    end else if (r_state == ST_CHARGE && w_wrap && r_v == V_MAX) begin
      r_to <= r_to + 1'b1;
    end
  end

  assign w_timeout = w_wrap && (r_v == V_MAX) && (r_to == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; disarm wins over release.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_press && i_arm) begin
          w_next = ST_CHARGE;
        end
      end
      ST_CHARGE: begin
        if (!i_arm) begin
          w_next = ST_IDLE;
        end else if (w_release || w_timeout) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_ack) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output logic, evaluated against the next state so the registered flags
  // change together with the state. Squeeze uses the current v, giving the
  // one-clock lag behind v; the entry cycle reports 0 instead of a stale v.
  assign w_sq_full = (r_v - V_MIN) >> SQ_SHIFT;

  always_comb begin
    w_charging_d = (w_next == ST_CHARGE);
    w_valid_d    = (w_next == ST_DONE);
    w_sq_d       = '0;
    if (r_state == ST_CHARGE && w_next == ST_CHARGE) begin
      if (w_sq_full > V_W'(SQUEEZE_MAX)) begin
        w_sq_d = SQUEEZE_MAX;
      end else begin
        w_sq_d = w_sq_full[3:0];
      end
    end
  end

  // Velocity datapath: every clock spent in CHARGE advances the tick counter,
  // including the clock that leaves CHARGE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick     <= '0;
      r_v        <= V_MIN;
      r_sq       <= '0;
      r_charging <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_sq       <= w_sq_d;
      r_charging <= w_charging_d;
      r_valid    <= w_valid_d;
      if (w_enter) begin
        r_tick <= '0;
        r_v    <= V_MIN;
      end else if (r_state == ST_CHARGE) begin
        if (w_wrap) begin
          r_tick <= '0;
          if (r_v != V_MAX) begin
            r_v <= r_v + 1'b1;
          end
        end else begin
          r_tick <= r_tick + 1'b1;
        end
      end
    end
  end

  assign o_charging = r_charging;
  assign o_squeeze  = r_sq;
  assign o_v_init   = r_v;
  assign o_valid    = r_valid;

endmodule

// File: tb/tb_btn_charge.sv
// tb_btn_charge: directed, table-driven bench for btn_charge with
// DEBOUNCE_CYCLES=4, TICK_CYCLES=2, V_MIN=10, V_MAX=40, SQ_SHIFT=1,
// TIMEOUT_TICKS=3. A raw hold of N clocks yields N clocks in CHARGE.
module tb_btn_charge;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       arm;
  logic       ack;
  logic       o_charging;
  logic [3:0] o_squeeze;
  logic [7:0] o_v_init;
  logic       o_valid;

  int checks = 0;
  int errors = 0;

  // Reference-model state, updated at each sample point
  logic       prev_chg = 1'b0;
  logic [7:0] prev_v   = 8'd10;
  int         n_chg    = 0;
  int         peak_sq  = 0;
  logic       saw_chg  = 1'b0;

  typedef struct {
    int   hold;
    logic exp_chg;
    int   exp_v;
    int   exp_peak;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  btn_charge #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (2),
    .V_MIN          (8'd10),
    .V_MAX          (8'd40),
    .SQ_SHIFT       (1),
    .TIMEOUT_TICKS  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_btn     (btn),
    .i_arm     (arm),
    .i_ack     (ack),
    .o_charging(o_charging),
    .o_squeeze (o_squeeze),
    .o_v_init  (o_v_init),
    .o_valid   (o_valid)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sq_of(input logic [7:0] v);
    int d;
    d = (int'(v) - 10) / 2;
    if (d > 14) d = 14;
    return d;
  endfunction

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    int exp_v;
    @(posedge clk);
    #1;
    if (o_charging) begin
      n_chg = prev_chg ? n_chg + 1 : 0;
      exp_v = 10 + n_chg / 2;
      if (exp_v > 40) exp_v = 40;
      chk("v_model", o_v_init, exp_v);
      chk("sq_model", o_squeeze, prev_chg ? sq_of(prev_v) : 0);
      if (o_squeeze > peak_sq) peak_sq = o_squeeze;
      saw_chg = 1'b1;
    end else begin
      chk("sq_zero", o_squeeze, 0);
    end
    prev_chg = o_charging;
    prev_v   = o_v_init;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 30) begin
      step();
      lat++;
    end
  endtask

  task automatic wait_v(input int target, output logic found);
    int k;
    k = 0;
    while (o_v_init != 8'(target) && k < 120) begin
      step();
      k++;
    end
    found = (o_v_init == 8'(target));
  endtask

  initial begin
    int   lat;
    logic found;

    vecs.push_back('{hold: 3,  exp_chg: 1'b0, exp_v: 0,  exp_peak: 0});
    vecs.push_back('{hold: 4,  exp_chg: 1'b1, exp_v: 12, exp_peak: 0});
    vecs.push_back('{hold: 9,  exp_chg: 1'b1, exp_v: 14, exp_peak: 1});
    vecs.push_back('{hold: 20, exp_chg: 1'b1, exp_v: 20, exp_peak: 4});
    vecs.push_back('{hold: 31, exp_chg: 1'b1, exp_v: 25, exp_peak: 7});
    vecs.push_back('{hold: 60, exp_chg: 1'b1, exp_v: 40, exp_peak: 14});
`ifndef BTN_CHARGE_TIMEOUT_EN
    vecs.push_back('{hold: 100, exp_chg: 1'b1, exp_v: 40, exp_peak: 14});
`endif

    rst = 1'b1;
    btn = 1'b0;
    arm = 1'b0;
    ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_charging", o_charging, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_squeeze", o_squeeze, 0);
    chk("rst_v_init", o_v_init, 10);
    rst = 1'b0;
    arm = 1'b1;
    repeat (4) step();

    // Table-driven press/hold/release transactions
    foreach (vecs[i]) begin
      saw_chg = 1'b0;
      peak_sq = 0;
      btn = 1'b1;
      repeat (vecs[i].hold) step();
      btn = 1'b0;
      wait_valid(lat);
      if (vecs[i].exp_chg) begin
        chk("valid_latency", lat, 7);
        chk("v_final", o_v_init, vecs[i].exp_v);
        chk("sq_peak", peak_sq, vecs[i].exp_peak);
        chk("sq_done", o_squeeze, 0);
        repeat (3) step();
        chk("valid_hold", o_valid, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("valid_clear", o_valid, 0);
        chk("v_hold_after_ack", o_v_init, vecs[i].exp_v);
      end else begin
        chk("short_no_charge", saw_chg, 0);
        chk("short_no_valid", o_valid, 0);
      end
      repeat (8) step();
    end

    // Reset asserted mid-charge at v=25 takes effect without a clock
    btn = 1'b1;
    wait_v(25, found);
    chk("reach_v25", found, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_charging", o_charging, 0);
    chk("midrst_v_init", o_v_init, 10);
    chk("midrst_squeeze", o_squeeze, 0);
    chk("midrst_valid", o_valid, 0);
    btn = 1'b0;
    prev_chg = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    saw_chg = 1'b0;
    repeat (10) step();
    chk("post_rst_idle", saw_chg, 0);

    // Bouncy input: never 4 consecutive high samples
    saw_chg = 1'b0;
    repeat (3) begin
      btn = 1'b1;
      repeat (3) step();
      btn = 1'b0;
      step();
    end
    repeat (15) step();
    chk("bounce_no_charge", saw_chg, 0);

    // Press while disarmed, then ack outside DONE
    arm = 1'b0;
    saw_chg = 1'b0;
    btn = 1'b1;
    repeat (10) step();
    btn = 1'b0;
    repeat (10) step();
    chk("disarm_no_charge", saw_chg, 0);
    arm = 1'b1;
    ack = 1'b1;
    repeat (5) step();
    ack = 1'b0;
    chk("ack_idle_valid", o_valid, 0);
    chk("ack_idle_charging", o_charging, 0);

    // Disarm at v=15: back to IDLE with v held; held button does not re-charge
    btn = 1'b1;
    wait_v(15, found);
    chk("reach_v15", found, 1);
    arm = 1'b0;
    step();
    chk("disarm_charging", o_charging, 0);
    chk("disarm_valid", o_valid, 0);
    chk("disarm_v", o_v_init, 15);
    repeat (5) step();
    chk("disarm_v_hold", o_v_init, 15);
    arm = 1'b1;
    saw_chg = 1'b0;
    repeat (20) step();
    chk("rearm_held_no_charge", saw_chg, 0);
    btn = 1'b0;
    repeat (12) step();
    chk("rearm_release_no_valid", o_valid, 0);
    chk("rearm_v_hold", o_v_init, 15);

    // Press while DONE is ignored; after ack a still-held button needs a fresh press
    btn = 1'b1;
    repeat (10) step();
    btn = 1'b0;
    wait_valid(lat);
    chk("done_seq_valid", o_valid, 1);
    chk("done_seq_v", o_v_init, 15);
    saw_chg = 1'b0;
    btn = 1'b1;
    repeat (12) step();
    chk("done_press_ignored", saw_chg, 0);
    chk("done_press_valid", o_valid, 1);
    chk("done_press_v", o_v_init, 15);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("done_ack_clear", o_valid, 0);
    repeat (10) step();
    chk("held_after_ack_no_charge", saw_chg, 0);
    btn = 1'b0;
    repeat (10) step();

`ifdef BTN_CHARGE_TIMEOUT_EN
    // Auto-release 3 tick wraps (6 clocks) after saturation
    btn = 1'b1;
    wait_v(40, found);
    chk("reach_v40", found, 1);
    wait_valid(lat);
    chk("timeout_latency", lat, 6);
    chk("timeout_v", o_v_init, 40);
    ack = 1'b1;
    step();
    ack = 1'b0;
    saw_chg = 1'b0;
    repeat (15) step();
    chk("timeout_held_no_charge", saw_chg, 0);
    btn = 1'b0;
    repeat (10) step();
    btn = 1'b1;
    repeat (10) step();
    chk("timeout_repress_charging", o_charging, 1);
    btn = 1'b0;
    wait_valid(lat);
    chk("timeout_repress_valid", o_valid, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    repeat (5) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
